// File: rtl/tmds_pkg.sv
// TMDS lane modes, symbol tables and scrambler constants shared by the encoder array.
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL  = 3'd0,
      MODE_VIDEO = 3'd1,
      MODE_VGB   = 3'd2,
      MODE_DATA  = 3'd3,
      MODE_DGB   = 3'd4
   } tmds_mode_e;

   localparam logic [9:0] CTRL_CODE [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   localparam logic [9:0] TERC4_CODE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   localparam logic [9:0] VGB_CH02 = 10'b1011001100;
   localparam logic [9:0] VGB_CH1  = 10'b0100110011;
   localparam logic [9:0] DGB_CH12 = 10'b0100110011;

   // x^16+x^5+x^4+x^3+1, shift-left Fibonacci form; lane c seeds at BASE - c
   localparam logic [15:0] LFSR_SEED_BASE = 16'hFFFF;
   localparam logic [15:0] LFSR_TAPS      = 16'h801C;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] cnt;
      cnt = '0;
      for (int i = 0; i < 8; i++) cnt = cnt + 4'(v[i]);
      return cnt;
   endfunction

endpackage

// File: rtl/tmds_lane_core.sv
// One TMDS lane: transition-minimising stage, DC-balancing stage and running disparity.
// Optional per-lane video scrambler when TMDS_SCRAMBLE_EN is defined.
module tmds_lane_core
   import tmds_pkg::*;
#(
`ifdef TMDS_SCRAMBLE_EN
   parameter int unsigned LANE   = 0,
`endif
   parameter int unsigned ROLE   = 0,
   parameter int unsigned DISP_W = 5
) (
   input  logic       clk_pixel,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic       s1_valid,
   input  logic [2:0] mode,
   input  logic [7:0] video_data,
   input  logic [3:0] terc4_nib,
   input  logic [1:0] control_data,
   output logic [9:0] tmds
);

   localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);

   logic [7:0] vid_in;
   logic [3:0] n1d;
   logic       use_xnor;
   logic [8:0] qm_c;

   logic [8:0] s1_qm;
   logic [3:0] s1_n1;
   logic [2:0] s1_mode;
   logic [1:0] s1_ctrl;
   logic [3:0] s1_nib;

   logic signed [DISP_W-1:0] acc;
   logic signed [DISP_W-1:0] acc_nxt;
   logic signed [DISP_W-1:0] diff;
   logic [9:0]               tmds_nxt;

`ifdef TMDS_SCRAMBLE_EN
   localparam logic [15:0] SEED = LFSR_SEED_BASE - 16'(LANE);

   logic [15:0] lfsr;
   logic [15:0] lfsr_adv;

   always_comb begin
      lfsr_adv = lfsr;
      for (int i = 0; i < 8; i++) lfsr_adv = {lfsr_adv[14:0], ^(lfsr_adv & LFSR_TAPS)};
   end

   // Control beats resynchronise the scrambler; every other valid beat consumes a byte
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n)      lfsr <= SEED;
      else if (in_valid) lfsr <= (mode == MODE_CTRL) ? SEED : lfsr_adv;
   end

   assign vid_in = (mode == MODE_VIDEO) ? (video_data ^ lfsr[7:0]) : video_data;
`else
   assign vid_in = video_data;
`endif

   assign n1d = popcount8(vid_in);

   // Stage 1: pick XOR/XNOR chain to minimise transitions
   always_comb begin
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !vid_in[0]);
      qm_c     = '0;
      qm_c[0]  = vid_in[0];
      for (int i = 1; i < 8; i++)
         qm_c[i] = use_xnor ? ~(qm_c[i-1] ^ vid_in[i]) : (qm_c[i-1] ^ vid_in[i]);
      qm_c[8]  = !use_xnor;
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         s1_qm   <= '0;
         s1_n1   <= '0;
         s1_mode <= '0;
         s1_ctrl <= '0;
         s1_nib  <= '0;
      end else if (in_valid) begin
         s1_qm   <= qm_c;
         s1_n1   <= popcount8(qm_c[7:0]);
         s1_mode <= mode;
         s1_ctrl <= control_data;
         s1_nib  <= terc4_nib;
      end
   end

   // Stage 2: symbol select and DC balance; acc only survives video beats
   always_comb begin
      tmds_nxt = CTRL_CODE[0];
      acc_nxt  = '0;
      diff     = DISP_W'(s1_n1) - DISP_W'(4'd8 - s1_n1);
      case (s1_mode)
         MODE_CTRL: tmds_nxt = CTRL_CODE[s1_ctrl];
         MODE_VIDEO: begin
            if ((acc == '0) || (s1_n1 == 4'd4)) begin
               tmds_nxt = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
               acc_nxt  = s1_qm[8] ? (acc + diff) : (acc - diff);
            end else if ((!acc[DISP_W-1] && (s1_n1 > 4'd4)) ||
                         ( acc[DISP_W-1] && (s1_n1 < 4'd4))) begin
               tmds_nxt = {1'b1, s1_qm[8], ~s1_qm[7:0]};
               acc_nxt  = acc - diff + (s1_qm[8] ? TWO : '0);
            end else begin
               tmds_nxt = {1'b0, s1_qm[8], s1_qm[7:0]};
               acc_nxt  = acc + diff - (s1_qm[8] ? '0 : TWO);
            end
         end
         MODE_VGB:  tmds_nxt = (ROLE == 1) ? VGB_CH1 : VGB_CH02;
         MODE_DATA: tmds_nxt = TERC4_CODE[s1_nib];
         MODE_DGB:  tmds_nxt = (ROLE == 0) ? TERC4_CODE[{2'b11, s1_ctrl}] : DGB_CH12;
         default:   tmds_nxt = CTRL_CODE[0];
      endcase
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         tmds <= CTRL_CODE[0];
         acc  <= '0;
      end else if (s1_valid) begin
         tmds <= tmds_nxt;
         acc  <= acc_nxt;
      end
   end

endmodule

// File: rtl/tmds_encoder_array.sv
// NUM_CHANNELS-lane pipelined TMDS encoder with valid pipeline and sticky illegal-mode flag.
// Define TMDS_SCRAMBLE_EN to enable the per-lane video scrambler.
module tmds_encoder_array
   import tmds_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 3,
   parameter int unsigned DISP_W       = 5
) (
   input  logic                       clk_pixel,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic [2:0]                 mode,
   input  logic [8*NUM_CHANNELS-1:0]  video_data,
   input  logic [4*NUM_CHANNELS-1:0]  data_island_data,
   input  logic [2*NUM_CHANNELS-1:0]  control_data,
   output logic                       out_valid,
   output logic [10*NUM_CHANNELS-1:0] tmds,
   output logic                       mode_err
);

   logic s1_valid;
   logic s1_illegal;

   // Valid pipeline; mode_err latches when an illegal beat reaches the output
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid   <= 1'b0;
         s1_illegal <= 1'b0;
         out_valid  <= 1'b0;
         mode_err   <= 1'b0;
      end else begin
         s1_valid   <= in_valid;
         s1_illegal <= in_valid && (mode > MODE_DGB);
         out_valid  <= s1_valid;
         if (s1_valid && s1_illegal) mode_err <= 1'b1;
      end
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
      tmds_lane_core #(
`ifdef TMDS_SCRAMBLE_EN
         .LANE         (c),
`endif
         .ROLE         (c % 3),
         .DISP_W       (DISP_W)
      ) u_lane (
         .clk_pixel    (clk_pixel),
         .reset_n      (reset_n),
         .in_valid     (in_valid),
         .s1_valid     (s1_valid),
         .mode         (mode),
         .video_data   (video_data[8*c +: 8]),
         .terc4_nib    (data_island_data[4*c +: 4]),
         .control_data (control_data[2*c +: 2]),
         .tmds         (tmds[10*c +: 10])
      );
   end

endmodule
